// File: rtl/gci_std_display_reg_initiator.sv
// Host-side register initiator for the display controller.
// Host requests (write or read) are queued in a small FIFO and replayed one at
// a time onto the display register port. Read data, or a timeout error when the
// target stays silent, is returned to the host under backpressure.
module gci_std_display_reg_initiator #(
  parameter int P_FIFO_DEPTH   = 4,
  parameter int P_FIFO_DEPTH_N = 2,
  parameter int P_TIMEOUT      = 16
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  // Host request side
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic        iREQ_RW,
  input  logic [3:0]  iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  // Host response side
  output logic        oRSP_VALID,
  input  logic        iRSP_BUSY,
  output logic [31:0] oRSP_DATA,
  output logic        oRSP_ERROR,
  // Register write port
  output logic        oWR_VALID,
  output logic [3:0]  oWR_ADDR,
  output logic [31:0] oWR_DATA,
  // Register read port
  output logic        oRD_VALID,
  input  logic        iRD_BUSY,
  output logic [3:0]  oRD_ADDR,
  input  logic        iRD_VALID,
  output logic        oRD_BUSY,
  input  logic [31:0] iRD_DATA
);

  localparam int EntryW = 1 + 4 + 32;
  localparam int TimerW = $clog2(P_TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(P_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
  localparam logic [P_FIFO_DEPTH_N:0] PtrOne = (P_FIFO_DEPTH_N + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadWait,
    StResp
  } state_e;

  // Request FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [EntryW-1:0]       fifoMem_q [P_FIFO_DEPTH];
  logic [P_FIFO_DEPTH_N:0] wrPtr_q;
  logic [P_FIFO_DEPTH_N:0] wrPtr_d;
  logic [P_FIFO_DEPTH_N:0] rdPtr_q;
  logic [P_FIFO_DEPTH_N:0] rdPtr_d;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic                    push;
  logic                    pop;
  logic [EntryW-1:0]       headEntry;
  logic                    headRw;
  logic [3:0]              headAddr;
  logic [31:0]             headData;

  // Sequencer state and registered outputs
  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic              wrValid_q;
  logic [3:0]        wrAddr_q;
  logic [31:0]       wrData_q;
  logic              rdValid_q;
  logic [3:0]        rdAddr_q;
  logic              rdBusy_q;
  logic              rspValid_q;
  logic [31:0]       rspData_q;
  logic              rspError_q;

  // Full/empty flags, handshakes and next pointers; a full FIFO refuses a push
  // even when the sequencer pops in the same cycle.
  always_comb begin
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (wrPtr_q[P_FIFO_DEPTH_N] != rdPtr_q[P_FIFO_DEPTH_N]) &&
                (wrPtr_q[P_FIFO_DEPTH_N-1:0] == rdPtr_q[P_FIFO_DEPTH_N-1:0]);
    push      = iREQ_VALID && !fifoFull;
    pop       = (state_q == StIdle) && !fifoEmpty;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PtrOne;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PtrOne;
    end
  end

  // Unpack the entry at the head of the FIFO
  always_comb begin
    headEntry = fifoMem_q[rdPtr_q[P_FIFO_DEPTH_N-1:0]];
    headRw    = headEntry[EntryW-1];
    headAddr  = headEntry[EntryW-2 -: 4];
    headData  = headEntry[31:0];
  end

  // FIFO storage needs no reset; only slots between the pointers are ever read
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      fifoMem_q[wrPtr_q[P_FIFO_DEPTH_N-1:0]] <= {iREQ_RW, iREQ_ADDR, iREQ_DATA};
    end
  end

  // FIFO pointers; reset empties the queue and drops pending requests
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Sequencer: issue one request at a time, strictly in FIFO order
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      wrValid_q  <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdValid_q  <= 1'b0;
      rdAddr_q   <= '0;
      rdBusy_q   <= 1'b1;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspError_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifoEmpty) begin
            if (headRw) begin
              wrValid_q <= 1'b1;
              wrAddr_q  <= headAddr;
              wrData_q  <= headData;
              state_q   <= StWrite;
            end else begin
              rdValid_q <= 1'b1;
              rdAddr_q  <= headAddr;
              state_q   <= StReadReq;
            end
          end
        end
        StWrite: begin
          wrValid_q <= 1'b0;
          state_q   <= StIdle;
        end
        StReadReq: begin
          if (!iRD_BUSY) begin
            rdValid_q <= 1'b0;
            rdBusy_q  <= 1'b0;
            timer_q   <= '0;
            state_q   <= StReadWait;
          end
        end
        StReadWait: begin
          if (iRD_VALID) begin
            rspData_q  <= iRD_DATA;
            rspError_q <= 1'b0;
            rspValid_q <= 1'b1;
            rdBusy_q   <= 1'b1;
            state_q    <= StResp;
          end else if (timer_q == TimerLast) begin
            rspData_q  <= '0;
            rspError_q <= 1'b1;
            rspValid_q <= 1'b1;
            rdBusy_q   <= 1'b1;
            state_q    <= StResp;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end
        StResp: begin
          if (!iRSP_BUSY) begin
            rspValid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive the ports straight from the registers
  always_comb begin
    oREQ_BUSY  = fifoFull;
    oRSP_VALID = rspValid_q;
    oRSP_DATA  = rspData_q;
    oRSP_ERROR = rspError_q;
    oWR_VALID  = wrValid_q;
    oWR_ADDR   = wrAddr_q;
    oWR_DATA   = wrData_q;
    oRD_VALID  = rdValid_q;
    oRD_ADDR   = rdAddr_q;
    oRD_BUSY   = rdBusy_q;
  end

endmodule

// File: tb/tb_gci_std_display_reg_initiator.sv
// Directed testbench for gci_std_display_reg_initiator.
// Each task drives one scenario and compares outputs against hand-derived values
// sampled 1 time unit after the rising clock edge.
module tb_gci_std_display_reg_initiator;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iREQ_VALID;
  logic        oREQ_BUSY;
  logic        iREQ_RW;
  logic [3:0]  iREQ_ADDR;
  logic [31:0] iREQ_DATA;
  logic        oRSP_VALID;
  logic        iRSP_BUSY;
  logic [31:0] oRSP_DATA;
  logic        oRSP_ERROR;
  logic        oWR_VALID;
  logic [3:0]  oWR_ADDR;
  logic [31:0] oWR_DATA;
  logic        oRD_VALID;
  logic        iRD_BUSY;
  logic [3:0]  oRD_ADDR;
  logic        iRD_VALID;
  logic        oRD_BUSY;
  logic [31:0] iRD_DATA;

  int checks   = 0;
  int failures = 0;

  gci_std_display_reg_initiator #(
    .P_FIFO_DEPTH   (4),
    .P_FIFO_DEPTH_N (2),
    .P_TIMEOUT      (16)
  ) dut (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iREQ_VALID  (iREQ_VALID),
    .oREQ_BUSY   (oREQ_BUSY),
    .iREQ_RW     (iREQ_RW),
    .iREQ_ADDR   (iREQ_ADDR),
    .iREQ_DATA   (iREQ_DATA),
    .oRSP_VALID  (oRSP_VALID),
    .iRSP_BUSY   (iRSP_BUSY),
    .oRSP_DATA   (oRSP_DATA),
    .oRSP_ERROR  (oRSP_ERROR),
    .oWR_VALID   (oWR_VALID),
    .oWR_ADDR    (oWR_ADDR),
    .oWR_DATA    (oWR_DATA),
    .oRD_VALID   (oRD_VALID),
    .iRD_BUSY    (iRD_BUSY),
    .oRD_ADDR    (oRD_ADDR),
    .iRD_VALID   (iRD_VALID),
    .oRD_BUSY    (oRD_BUSY),
    .iRD_DATA    (iRD_DATA)
  );

  // Free-running 10-unit clock
  always #5 iCLOCK = ~iCLOCK;

  // Guard against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic test_reset();
    logic [77:0] obs;
    iRESET_SYNC = 1'b1;
    step();
    step();
    obs = {oREQ_BUSY, oRSP_VALID, oRSP_DATA, oRSP_ERROR, oWR_VALID, oWR_ADDR,
           oWR_DATA, oRD_VALID, oRD_ADDR, oRD_BUSY};
    checks++;
    if (obs !== 78'd1) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h want %h", obs, 78'd1);
    end
    iRESET_SYNC = 1'b0;
    step();
  endtask

  task automatic test_write();
    iREQ_VALID = 1'b1; iREQ_RW = 1'b1; iREQ_ADDR = 4'h2; iREQ_DATA = 32'h0000_0005;
    checks++;
    if (oREQ_BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_accept_busy: got %b want 0", oREQ_BUSY);
    end
    step();
    iREQ_VALID = 1'b0;
    checks++;
    if (oWR_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_early_strobe: got %b want 0 at N+1", oWR_VALID);
    end
    step();
    checks++;
    if ({oWR_VALID, oWR_ADDR, oWR_DATA} !== {1'b1, 4'h2, 32'h0000_0005}) begin
      failures++;
      $display("[TB] FAIL write_strobe: got v=%b a=%h d=%h want v=1 a=2 d=00000005",
               oWR_VALID, oWR_ADDR, oWR_DATA);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (oWR_VALID !== 1'b0 || oRSP_VALID !== 1'b0) begin
        failures++;
        $display("[TB] FAIL write_after: got wr=%b rsp=%b want 0 0 (cycle %0d)",
                 oWR_VALID, oRSP_VALID, i);
      end
    end
  endtask

  task automatic test_read();
    iREQ_VALID = 1'b1; iREQ_RW = 1'b0; iREQ_ADDR = 4'h3; iREQ_DATA = 32'h0;
    step();
    iREQ_VALID = 1'b0;
    step();
    checks++;
    if ({oRD_VALID, oRD_ADDR, oRD_BUSY} !== {1'b1, 4'h3, 1'b1}) begin
      failures++;
      $display("[TB] FAIL read_req: got v=%b a=%h busy=%b want v=1 a=3 busy=1",
               oRD_VALID, oRD_ADDR, oRD_BUSY);
    end
    step();
    checks++;
    if ({oRD_VALID, oRD_BUSY, oRSP_VALID} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL read_wait: got rdv=%b rdbusy=%b rspv=%b want 0 0 0",
               oRD_VALID, oRD_BUSY, oRSP_VALID);
    end
    iRD_VALID = 1'b1; iRD_DATA = 32'h0004_B000;
    step();
    iRD_VALID = 1'b0; iRD_DATA = 32'h0;
    checks++;
    if ({oRSP_VALID, oRSP_DATA, oRSP_ERROR} !== {1'b1, 32'h0004_B000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL read_rsp: got v=%b d=%h e=%b want v=1 d=0004b000 e=0",
               oRSP_VALID, oRSP_DATA, oRSP_ERROR);
    end
    step();
    checks++;
    if (oRSP_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_rsp_drop: got %b want 0", oRSP_VALID);
    end
  endtask

  task automatic test_read_stall();
    int handshakes = 0;
    iRD_BUSY = 1'b1; iRSP_BUSY = 1'b1;
    iREQ_VALID = 1'b1; iREQ_RW = 1'b0; iREQ_ADDR = 4'hA;
    step();
    iREQ_VALID = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (oRD_VALID !== 1'b1 || oRD_ADDR !== 4'hA) begin
        failures++;
        $display("[TB] FAIL stall_rd_hold: got v=%b a=%h want v=1 a=a (cycle %0d)",
                 oRD_VALID, oRD_ADDR, i);
      end
      step();
    end
    iRD_BUSY = 1'b0;
    checks++;
    if (oRD_VALID !== 1'b1 || oRD_ADDR !== 4'hA) begin
      failures++;
      $display("[TB] FAIL stall_rd_release: got v=%b a=%h want v=1 a=a", oRD_VALID, oRD_ADDR);
    end
    step();
    checks++;
    if (oRD_VALID !== 1'b0 || oRD_BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_rd_accept: got v=%b busy=%b want 0 0", oRD_VALID, oRD_BUSY);
    end
    iRD_VALID = 1'b1; iRD_DATA = 32'h1357_9BDF;
    step();
    iRD_VALID = 1'b0; iRD_DATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({oRSP_VALID, oRSP_DATA, oRSP_ERROR} !== {1'b1, 32'h1357_9BDF, 1'b0}) begin
        failures++;
        $display("[TB] FAIL stall_rsp_hold: got v=%b d=%h e=%b want v=1 d=13579bdf e=0",
                 oRSP_VALID, oRSP_DATA, oRSP_ERROR);
      end
      step();
    end
    iRSP_BUSY = 1'b0;
    checks++;
    if ({oRSP_VALID, oRSP_DATA} !== {1'b1, 32'h1357_9BDF}) begin
      failures++;
      $display("[TB] FAIL stall_rsp_release: got v=%b d=%h want v=1 d=13579bdf",
               oRSP_VALID, oRSP_DATA);
    end
    for (int i = 0; i < 6; i++) begin
      if (oRSP_VALID && !iRSP_BUSY) handshakes++;
      step();
    end
    checks++;
    if (handshakes != 1) begin
      failures++;
      $display("[TB] FAIL stall_rsp_count: got %0d responses want 1", handshakes);
    end
  endtask

  task automatic test_timeout();
    iREQ_VALID = 1'b1; iREQ_RW = 1'b0; iREQ_ADDR = 4'h5;
    step();
    iREQ_VALID = 1'b0;
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (oRSP_VALID !== 1'b0) begin
        failures++;
        $display("[TB] FAIL timeout_early: got %b want 0 (wait cycle %0d)", oRSP_VALID, i);
      end
      step();
    end
    checks++;
    if (oRSP_VALID !== 1'b0 || oRD_BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_last_wait: got rspv=%b rdbusy=%b want 0 0", oRSP_VALID, oRD_BUSY);
    end
    step();
    checks++;
    if ({oRSP_VALID, oRSP_DATA, oRSP_ERROR, oRD_BUSY} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL timeout_rsp: got v=%b d=%h e=%b rdbusy=%b want v=1 d=0 e=1 rdbusy=1",
               oRSP_VALID, oRSP_DATA, oRSP_ERROR, oRD_BUSY);
    end
    step();
    iRD_VALID = 1'b1; iRD_DATA = 32'hFFFF_FFFF;
    step();
    iRD_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (oRSP_VALID !== 1'b0) begin
        failures++;
        $display("[TB] FAIL timeout_stray: got %b want 0 (cycle %0d)", oRSP_VALID, i);
      end
      step();
    end
  endtask

  task automatic test_timeout_tie();
    iREQ_VALID = 1'b1; iREQ_RW = 1'b0; iREQ_ADDR = 4'h6;
    step();
    iREQ_VALID = 1'b0;
    step();
    step();
    for (int i = 0; i < 15; i++) step();
    iRD_VALID = 1'b1; iRD_DATA = 32'h0000_1234;
    step();
    iRD_VALID = 1'b0;
    checks++;
    if ({oRSP_VALID, oRSP_DATA, oRSP_ERROR} !== {1'b1, 32'h0000_1234, 1'b0}) begin
      failures++;
      $display("[TB] FAIL timeout_tie: got v=%b d=%h e=%b want v=1 d=00001234 e=0",
               oRSP_VALID, oRSP_DATA, oRSP_ERROR);
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [36:0] expA;
    logic [36:0] expB;
    expA = {1'b1, 4'h8, 32'h0000_00AA};
    expB = {1'b1, 4'h9, 32'h0000_00BB};
    iREQ_VALID = 1'b1; iREQ_RW = 1'b1; iREQ_ADDR = 4'h8; iREQ_DATA = 32'h0000_00AA;
    step();
    iREQ_ADDR = 4'h9; iREQ_DATA = 32'h0000_00BB;
    step();
    iREQ_VALID = 1'b0;
    checks++;
    if ({oWR_VALID, oWR_ADDR, oWR_DATA} !== expA) begin
      failures++;
      $display("[TB] FAIL b2b_first: got v=%b a=%h d=%h want v=1 a=8 d=000000aa",
               oWR_VALID, oWR_ADDR, oWR_DATA);
    end
    step();
    checks++;
    if (oWR_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got %b want 0", oWR_VALID);
    end
    step();
    checks++;
    if ({oWR_VALID, oWR_ADDR, oWR_DATA} !== expB) begin
      failures++;
      $display("[TB] FAIL b2b_second: got v=%b a=%h d=%h want v=1 a=9 d=000000bb",
               oWR_VALID, oWR_ADDR, oWR_DATA);
    end
    step();
    checks++;
    if (oWR_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_end: got %b want 0", oWR_VALID);
    end
  endtask

  task automatic test_fifo_full();
    logic [3:0]  wAddr [5];
    logic [31:0] wData [5];
    int          idx       = 0;
    int          acceptIdx = -1;
    logic        accepted;
    for (int i = 0; i < 5; i++) begin
      wAddr[i] = 4'(i + 1);
      wData[i] = 32'h0000_0100 + 32'(i);
    end
    iRD_BUSY = 1'b1;
    iREQ_VALID = 1'b1; iREQ_RW = 1'b0; iREQ_ADDR = 4'h7; iREQ_DATA = 32'h0;
    step();
    for (int i = 0; i < 4; i++) begin
      iREQ_RW = 1'b1; iREQ_ADDR = wAddr[i]; iREQ_DATA = wData[i];
      checks++;
      if (oREQ_BUSY !== 1'b0) begin
        failures++;
        $display("[TB] FAIL full_early_busy: got %b want 0 (write %0d)", oREQ_BUSY, i);
      end
      step();
    end
    iREQ_ADDR = wAddr[4]; iREQ_DATA = wData[4];
    checks++;
    if (oREQ_BUSY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_busy: got %b want 1", oREQ_BUSY);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({oREQ_BUSY, oWR_VALID, oRD_VALID, oRD_ADDR} !== {1'b1, 1'b0, 1'b1, 4'h7}) begin
        failures++;
        $display("[TB] FAIL full_hold: got busy=%b wr=%b rdv=%b rda=%h want 1 0 1 7",
                 oREQ_BUSY, oWR_VALID, oRD_VALID, oRD_ADDR);
      end
    end
    iRD_BUSY = 1'b0;
    step();
    iRD_VALID = 1'b1; iRD_DATA = 32'hCAFE_F00D;
    step();
    iRD_VALID = 1'b0;
    checks++;
    if ({oRSP_VALID, oRSP_DATA, oWR_VALID, oREQ_BUSY} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL full_read_rsp: got v=%b d=%h wr=%b busy=%b want 1 cafef00d 0 1",
               oRSP_VALID, oRSP_DATA, oWR_VALID, oREQ_BUSY);
    end
    for (int c = 0; c < 40; c++) begin
      accepted = iREQ_VALID && !oREQ_BUSY;
      if (accepted) acceptIdx = idx;
      step();
      if (accepted) iREQ_VALID = 1'b0;
      if (oWR_VALID) begin
        checks++;
        if (idx >= 5 || oWR_ADDR !== wAddr[idx % 5] || oWR_DATA !== wData[idx % 5]) begin
          failures++;
          $display("[TB] FAIL full_order: got a=%h d=%h want write %0d of 5", oWR_ADDR, oWR_DATA, idx);
        end
        idx++;
      end
      if (idx >= 5 && !iREQ_VALID) break;
    end
    checks++;
    if (idx != 5) begin
      failures++;
      $display("[TB] FAIL full_write_count: got %0d want 5", idx);
    end
    checks++;
    if (acceptIdx != 1) begin
      failures++;
      $display("[TB] FAIL full_fifth_accept: accepted after %0d strobes, want 1", acceptIdx);
    end
    iREQ_VALID = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    logic [77:0] obs;
    iRD_BUSY = 1'b0; iRSP_BUSY = 1'b0;
    iREQ_VALID = 1'b1; iREQ_RW = 1'b0; iREQ_ADDR = 4'h4; iREQ_DATA = 32'h0;
    step();
    iREQ_RW = 1'b1; iREQ_ADDR = 4'hC; iREQ_DATA = 32'h0000_0001;
    step();
    iREQ_ADDR = 4'hD; iREQ_DATA = 32'h0000_0002;
    step();
    iREQ_VALID = 1'b0;
    checks++;
    if (oRD_BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_in_wait: got rdbusy=%b want 0", oRD_BUSY);
    end
    iRESET_SYNC = 1'b1;
    step();
    iRESET_SYNC = 1'b0;
    obs = {oREQ_BUSY, oRSP_VALID, oRSP_DATA, oRSP_ERROR, oWR_VALID, oWR_ADDR,
           oWR_DATA, oRD_VALID, oRD_ADDR, oRD_BUSY};
    checks++;
    if (obs !== 78'd1) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got %h want %h", obs, 78'd1);
    end
    iRD_VALID = 1'b1; iRD_DATA = 32'h0000_0077;
    step();
    iRD_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (oWR_VALID !== 1'b0 || oRSP_VALID !== 1'b0 || oRD_VALID !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_quiet: got wr=%b rsp=%b rd=%b want 0 0 0 (cycle %0d)",
                 oWR_VALID, oRSP_VALID, oRD_VALID, i);
      end
      step();
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    iRESET_SYNC = 1'b1;
    iREQ_VALID  = 1'b0;
    iREQ_RW     = 1'b0;
    iREQ_ADDR   = 4'h0;
    iREQ_DATA   = 32'h0;
    iRSP_BUSY   = 1'b0;
    iRD_BUSY    = 1'b0;
    iRD_VALID   = 1'b0;
    iRD_DATA    = 32'h0;
    $display("[TB] starting gci_std_display_reg_initiator bench");
    test_reset();
    test_write();
    test_read();
    test_read_stall();
    test_timeout();
    test_timeout_tie();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
